// File: rtl/addsub_seq_nbit.sv
// addsub_seq_nbit: N-bit add/subtract over a reused K-bit slice, one chunk per clock.
// Optional signed saturation when ADDSUB_SAT_EN is defined. Rev 1.0
`default_nettype none

module addsub_seq_nbit #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         add_n,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         ovf
);

  localparam int M    = N / K;
  localparam int IDXW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [N-1:0]    x_q;
  logic [N-1:0]    y_q;
  logic [N-1:0]    acc_q;
  logic            sub_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic            busy_q;
  logic            done_q;
  logic [N-1:0]    s_q;
  logic            c_out_q;
  logic            ovf_q;

  logic [K-1:0]    xa_d;
  logic [K-1:0]    yb_d;
  logic [K-1:0]    sum_d;
  logic            cout_d;
  logic            cmsb_d;
  logic            ovf_d;
  logic [N-1:0]    acc_d;
  logic [N-1:0]    res_d;

  always_comb begin
    xa_d            = x_q[idx_q*K +: K];
    yb_d            = y_q[idx_q*K +: K] ^ {K{sub_q}};
    {cout_d, sum_d} = {1'b0, xa_d} + {1'b0, yb_d} + {{K{1'b0}}, carry_q};
    // Carry into the top bit of the slice, recovered from that bit's sum
    cmsb_d          = sum_d[K-1] ^ xa_d[K-1] ^ yb_d[K-1];
    ovf_d           = cmsb_d ^ cout_d;
    acc_d           = acc_q;
    acc_d[idx_q*K +: K] = sum_d;
    res_d           = acc_d;
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      res_d = x_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q     <= x;
            y_q     <= y;
            sub_q   <= add_n;
            carry_q <= add_n;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          carry_q <= cout_d;
          idx_q   <= idx_q + 1'b1;
          // Visible result only changes here, never mid-operation
          if (idx_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= res_d;
            c_out_q <= cout_d;
            ovf_q   <= ovf_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_addsub_seq_nbit.sv
// Scoreboard bench for addsub_seq_nbit: N=16/K=4 plus N=8 with K=8 and K=1.
`default_nettype none

module tb_addsub_seq_nbit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, add_n;
  logic [15:0] x, y;
  logic        busy, done, c_out, ovf;
  logic [15:0] s;

  logic        start8, add_n8;
  logic [7:0]  x8, y8;
  logic        busy_a, done_a, c_a, o_a;
  logic [7:0]  s_a;
  logic        busy_b, done_b, c_b, o_b;
  logic [7:0]  s_b;

  addsub_seq_nbit #(.N(16), .K(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .add_n(add_n), .x(x), .y(y),
    .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf));

  addsub_seq_nbit #(.N(8), .K(8)) u_m1 (
    .clk(clk), .reset_n(reset_n), .start(start8), .add_n(add_n8), .x(x8), .y(y8),
    .busy(busy_a), .done(done_a), .s(s_a), .c_out(c_a), .ovf(o_a));

  addsub_seq_nbit #(.N(8), .K(1)) u_m8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .add_n(add_n8), .x(x8), .y(y8),
    .busy(busy_b), .done(done_b), .s(s_b), .c_out(c_b), .ovf(o_b));

  typedef struct {
    longint s;
    bit     c;
    bit     o;
    int     acc;
  } exp_t;

  exp_t q16[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t e16, ea, eb;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] prev_s = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on width-w operands
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit sub, input int acc_cyc);
    exp_t   e;
    longint mask, half, u, sa, sb, ideal;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    u     = a + (sub ? (mask - b) : b) + (sub ? 1 : 0);
    sa    = (a >= half) ? a - (mask + 1) : a;
    sb    = (b >= half) ? b - (mask + 1) : b;
    ideal = sub ? sa - sb : sa + sb;
    e.c   = ((u >> w) & 1) != 0;
    e.o   = (ideal > half - 1) || (ideal < -half);
    e.s   = u & mask;
`ifdef ADDSUB_SAT_EN
    if (e.o) e.s = (ideal > 0) ? half - 1 : half;
`endif
    e.acc = acc_cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (q16.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done16: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e16 = q16.pop_front();
        check("s16", 64'(s), e16.s);
        check("c_out16", 64'(c_out), 64'(e16.c));
        check("ovf16", 64'(ovf), 64'(e16.o));
        check("latency16", 64'(cyc - e16.acc), 64'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && done_a) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done_k8: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        check("s_k8", 64'(s_a), ea.s);
        check("c_out_k8", 64'(c_a), 64'(ea.c));
        check("ovf_k8", 64'(o_a), 64'(ea.o));
        check("latency_k8", 64'(cyc - ea.acc), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && done_b) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done_k1: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        check("s_k1", 64'(s_b), eb.s);
        check("c_out_k1", 64'(c_b), 64'(eb.c));
        check("ovf_k1", 64'(o_b), 64'(eb.o));
        check("latency_k1", 64'(cyc - eb.acc), 64'd8);
      end
    end
  end

  // pre: start already high with a/b at this negedge. chain: hold start with next operands.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sub,
                      input bit junk, input bit pre, input bit chain,
                      input logic [15:0] ca, input logic [15:0] cb, input bit csub);
    exp_t e;
    if (!pre) begin
      @(negedge clk);
      x = a; y = b; add_n = sub; start = 1'b1;
    end
    e = model(16, longint'(a), longint'(b), sub, cyc + 1);
    q16.push_back(e);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("busy_run16", 64'(busy), 64'd1);
      check("s_hold16", 64'(s), 64'(prev_s));
      if (chain) begin
        x = ca; y = cb; add_n = csub; start = 1'b1;
      end else begin
        x = 16'($urandom); y = 16'($urandom); add_n = 1'($urandom);
        start = junk && (j < 3);
      end
    end
    @(negedge clk);
    check("busy_end16", 64'(busy), 64'd0);
    prev_s = e.s[15:0];
    if (!chain) start = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sub);
    @(negedge clk);
    x8 = a; y8 = b; add_n8 = sub; start8 = 1'b1;
    qa.push_back(model(8, longint'(a), longint'(b), sub, cyc + 1));
    qb.push_back(model(8, longint'(a), longint'(b), sub, cyc + 1));
    @(negedge clk);
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    repeat (9) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; add_n = 1'b0; x = '0; y = '0;
    start8 = 1'b0; add_n8 = 1'b0; x8 = '0; y8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;

    op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    op16(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    op16(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    op16(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    op16(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    // start held through done: next operation accepted the cycle after done
    op16(16'h4321, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 16'h9000, 16'hA000, 1'b0);
    op16(16'h9000, 16'hA000, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0,
           '0, '0, 1'b0);
    end

    // Abort by reset mid-operation: no done, outputs cleared at once
    @(negedge clk);
    x = 16'h0F0F; y = 16'h0101; add_n = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_s", 64'(s), 64'd0);
    check("abort_c_out", 64'(c_out), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    prev_s = 16'h0;
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(q16.size()), 64'd0);
    op16(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    op8(8'hFF, 8'h01, 1'b0);
    op8(8'h7F, 8'h01, 1'b0);
    op8(8'h80, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));

    for (int i = 0; i < 20; i++) begin
      if (q16.size() == 0 && qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    check("drain16", 64'(q16.size()), 64'd0);
    check("drain_k8", 64'(qa.size()), 64'd0);
    check("drain_k1", 64'(qb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
